dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the core's data-memory port: accepts one load/store request at a time from
//  the MA stage, services it against an internal word-organised RAM after WAIT_STATES cycles,
//  and drives stall back to the pipeline hazard logic while busy. Load data is returned
//  right-aligned (byte/half shifted to bit 0), so the core's load-width unit extends from bit 0.
// PARAMETERS
//  WIDTH        32   data/address width
//  DEPTH_LOG2   10   log2 of RAM depth in words (1024 words)
//  WAIT_STATES  1    extra busy cycles before the access is performed (0..15)
// PORTS
//  clk          in   1      clock
//  reset        in   1      reset, synchronous, active-high
//  req_valid    in   1      request present; core holds all req_* stable while stall=1
//  req_we       in   1      1=store, 0=load
//  req_size     in   2      00=word, 01=half, 10=byte, 11=reserved (treated as word)
//  req_addr     in   WIDTH  byte address
//  req_wdata    in   WIDTH  store data, right-aligned
//  stall        out  1      hold MA stage (combinational)
//  rsp_valid    out  1      one-cycle completion pulse
//  rsp_rdata    out  WIDTH  load data, right-aligned, zero above size; 0 for stores/errors
//  rsp_err      out  1      misaligned access, valid with rsp_valid
// BEHAVIOUR
//  - Reset: state=IDLE, wait counter=0, stall=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//    RAM contents are not cleared; a pending store at reset time is discarded.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: when req_valid=1, capture the request and load cnt=WAIT_STATES; go to BUSY.
//    BUSY: while cnt!=0, decrement. When cnt==0, perform the access at this edge and go to DONE.
//      A store writes only the enabled byte lanes. A load registers the aligned word.
//    DONE: rsp_valid=1 for exactly this cycle. Always return to IDLE. A req_valid seen in DONE
//      is not accepted until the next IDLE cycle.
//  - stall = (IDLE & req_valid) | BUSY; stall is 0 in DONE. Latency is acceptance edge to
//    rsp_valid = WAIT_STATES+2 cycles.
//  - Word index = addr[DEPTH_LOG2+1:2]; upper address bits are ignored, so accesses wrap.
//  - Byte enables: word 1111; half 0011<<addr[1]*2; byte 0001<<addr[1:0].
//  - Store data is replicated into the lanes. Load data is shifted right by addr[1:0]*8 and
//    masked to the size.
//  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. No RAM write, rsp_rdata=0,
//    rsp_err=1 together with rsp_valid in DONE. Timing is the same as a normal access.
//  - rsp_rdata/rsp_err are registered and hold their value outside DONE. They are meaningful
//    only while rsp_valid=1.
//  - Back-to-back requests: at most one every WAIT_STATES+3 cycles (IDLE gap after DONE).
// STRUCTURE
//  - Shared package: size encodings (SZ_WORD/SZ_HALF/SZ_BYTE) and FSM state encoding
//    (ST_IDLE/ST_BUSY/ST_DONE).
//  - Sub-module dmem_lane_align (combinational): size+addr[1:0]+wdata -> byte enables,
//    replicated wdata and misalign flag; raw word -> right-aligned rdata.
//  - RAM is a reg array with per-byte write; registered read in the BUSY completion cycle.
// TESTING
//  1 Reset mid-BUSY (store of 32'hDEADBEEF to 0x10, WAIT_STATES=3, reset at cnt=1)
//    -> IDLE, stall=0, no rsp_valid; a later word load of 0x10 returns the old value.
//  2 SW 0x12345678 @0x20, then LW @0x20 -> rsp_rdata=0x12345678, rsp_err=0;
//    stall high for exactly WAIT_STATES+1 cycles per request.
//  3 SB 0xAB @0x21, then LW @0x20 -> 0x1234AB78; LB @0x21 -> 0x000000AB.
//  4 SH 0xBEEF @0x22, then LH @0x22 -> 0x0000BEEF; LW @0x20 -> 0xBEEFAB78.
//  5 LW @0x22 and SH @0x23 -> rsp_err=1, rsp_rdata=0, RAM unchanged (check by LW @0x20).
//  6 Wrap: SW 0xCAFEF00D @ (1<<(DEPTH_LOG2+2))+0x4, then LW @0x4 -> 0xCAFEF00D;
//    with WAIT_STATES=0, latency acceptance->rsp_valid = 2 cycles.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, lane count.
package dmem_responder_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory port between the MA stage (master) and the responder (slave).
interface dmem_responder_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_we;
    logic [1:0]       req_size;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             stall;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  stall, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output stall, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/replication/misalign on the write side,
// right-alignment and size masking of the read word on the read side.
module dmem_lane_align
    import dmem_responder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       wr_size,
    input  logic [1:0]       wr_off,
    input  logic [WIDTH-1:0] wdata,
    output logic [LANES-1:0] be,
    output logic [WIDTH-1:0] wdata_rep,
    output logic             misaligned,
    input  logic [1:0]       rd_size,
    input  logic [1:0]       rd_off,
    input  logic [WIDTH-1:0] raw_word,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] shifted;

    always_comb begin
        be         = 4'b1111;
        misaligned = (wr_off != 2'b00);
        case (wr_size)
            SZ_HALF: begin
                be         = 4'b0011 << {wr_off[1], 1'b0};
                misaligned = wr_off[0];
            end
            SZ_BYTE: begin
                be         = 4'b0001 << wr_off;
                misaligned = 1'b0;
            end
            default: ;
        endcase
    end

    // Each lane takes the byte of the store data that lands there once replicated.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_rep
        always_comb begin
            case (wr_size)
                SZ_HALF: wdata_rep[gi*8 +: 8] = wdata[(gi % 2)*8 +: 8];
                SZ_BYTE: wdata_rep[gi*8 +: 8] = wdata[7:0];
                default: wdata_rep[gi*8 +: 8] = wdata[gi*8 +: 8];
            endcase
        end
    end

    always_comb begin
        shifted = raw_word >> {rd_off, 3'b000};
        case (rd_size)
            SZ_HALF: rdata = shifted & WIDTH'(16'hFFFF);
            SZ_BYTE: rdata = shifted & WIDTH'(8'hFF);
            default: rdata = shifted;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states and
// an internal byte-writable word RAM.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           reset,
    dmem_responder_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2 + 2;

    state_e           state_reg, state_next;
    logic [3:0]       cnt_reg;
    logic             we_reg;
    logic [1:0]       size_reg;
    logic [AW-1:0]    addr_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic [1:0]       rsp_size_reg, rsp_off_reg;
    logic             zero_reg, err_reg;
    logic [WIDTH-1:0] rd_word_reg;
    logic             accept, complete;
    logic [LANES-1:0] be;
    logic [WIDTH-1:0] wdata_rep, rd_aligned;
    logic             misaligned;
    logic [WIDTH-1:0] mem [DEPTH];

    dmem_lane_align #(.WIDTH(WIDTH)) u_align (
        .wr_size    (size_reg),
        .wr_off     (addr_reg[1:0]),
        .wdata      (wdata_reg),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .misaligned (misaligned),
        .rd_size    (rsp_size_reg),
        .rd_off     (rsp_off_reg),
        .raw_word   (rd_word_reg),
        .rdata      (rd_aligned)
    );

    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.req_valid) state_next = ST_BUSY;
            ST_BUSY: if (cnt_reg == 4'd0) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        accept        = 1'b0;
        complete      = 1'b0;
        bus.stall     = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                accept    = bus.req_valid;
                bus.stall = bus.req_valid;
            end
            ST_BUSY: begin
                bus.stall = 1'b1;
                complete  = (cnt_reg == 4'd0);
            end
            ST_DONE: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Response fields are latched only on completion so they hold between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg      <= 4'd0;
            we_reg       <= 1'b0;
            size_reg     <= SZ_WORD;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rsp_size_reg <= SZ_WORD;
            rsp_off_reg  <= 2'b00;
            zero_reg     <= 1'b1;
            err_reg      <= 1'b0;
        end else begin
            if (accept) begin
                cnt_reg   <= 4'(WAIT_STATES);
                we_reg    <= bus.req_we;
                size_reg  <= bus.req_size;
                addr_reg  <= bus.req_addr[AW-1:0];
                wdata_reg <= bus.req_wdata;
            end else if (state_reg == ST_BUSY && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (complete) begin
                rsp_size_reg <= size_reg;
                rsp_off_reg  <= addr_reg[1:0];
                zero_reg     <= we_reg | misaligned;
                err_reg      <= misaligned;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_word_reg <= '0;
        end else if (complete) begin
            rd_word_reg <= mem[addr_reg[AW-1:2]];
            if (we_reg && !misaligned) begin
                for (int li = 0; li < LANES; li++) begin
                    if (be[li]) mem[addr_reg[AW-1:2]][li*8 +: 8] <= wdata_rep[li*8 +: 8];
                end
            end
        end
    end

    assign bus.rsp_rdata = zero_reg ? '0 : rd_aligned;
    assign bus.rsp_err   = err_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed checks of two responders (3 and 0 wait states) against a byte-array model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk = 1'b0;
    logic reset_a, reset_b;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] mdl [0:1][0:4095];

    always #5 clk = ~clk;

    dmem_responder_if #(.WIDTH(32)) ifa ();
    dmem_responder_if #(.WIDTH(32)) ifb ();

    dmem_responder #(.WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(3)) dut_a (
        .clk(clk), .reset(reset_a), .bus(ifa));
    dmem_responder #(.WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut_b (
        .clk(clk), .reset(reset_b), .bus(ifb));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int w);
        return (w == 0) ? 3 : 0;
    endfunction

    function automatic logic g_stall(input int w);
        return (w == 0) ? ifa.stall : ifb.stall;
    endfunction
    function automatic logic g_rv(input int w);
        return (w == 0) ? ifa.rsp_valid : ifb.rsp_valid;
    endfunction
    function automatic logic [31:0] g_rd(input int w);
        return (w == 0) ? ifa.rsp_rdata : ifb.rsp_rdata;
    endfunction
    function automatic logic g_err(input int w);
        return (w == 0) ? ifa.rsp_err : ifb.rsp_err;
    endfunction

    task automatic drive(input int w, input bit v, input bit we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        if (w == 0) begin
            ifa.req_valid = v; ifa.req_we = we; ifa.req_size = sz;
            ifa.req_addr = a; ifa.req_wdata = d;
        end else begin
            ifb.req_valid = v; ifb.req_we = we; ifb.req_size = sz;
            ifb.req_addr = a; ifb.req_wdata = d;
        end
    endtask

    function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return a[0];
        if (sz == 2'd2) return 1'b0;
        return a[1:0] != 2'b00;
    endfunction

    function automatic int model_bytes(input logic [1:0] sz);
        return (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
    endfunction

    // One full transaction; returns response and measured timing.
    task automatic access(input int w, input bit we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err, output int lat,
                          output int stall_cyc);
        bit got_rsp;
        @(negedge clk);
        drive(w, 1'b1, we, sz, a, d);
        #1;
        check_eq("stall_on_request", 32'(g_stall(w)), 32'd1);
        lat = 0; stall_cyc = 0; got_rsp = 1'b0; rd = '0; err = 1'b0;
        for (int k = 0; k < 40 && !got_rsp; k++) begin
            @(posedge clk); #1;
            lat++;
            if (g_rv(w)) begin
                got_rsp = 1'b1;
                rd  = g_rd(w);
                err = g_err(w);
                check_eq("stall_in_done", 32'(g_stall(w)), 32'd0);
            end else if (g_stall(w)) begin
                stall_cyc++;
            end
        end
        if (!got_rsp) check_eq("rsp_timeout", 32'(lat), 32'(ws_of(w) + 2));
        drive(w, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check_eq("rsp_pulse_width", 32'(g_rv(w)), 32'd0);
        check_eq("rdata_hold", g_rd(w), rd);
    endtask

    task automatic op(input int w, input bit we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        err, exp_err;
        int          lat, stall_cyc, nb, base;
        exp_err = model_mis(sz, a);
        nb      = model_bytes(sz);
        base    = int'(a[11:0]);
        exp_rd  = '0;
        if (!exp_err && !we)
            for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = mdl[w][(base + i) & 12'hFFF];
        access(w, we, sz, a, d, rd, err, lat, stall_cyc);
        if (!exp_err && we)
            for (int i = 0; i < nb; i++) mdl[w][(base + i) & 12'hFFF] = d[8*i +: 8];
        $display("[TB] dut%0d %s sz=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d stall=%0d",
                 w, we ? "ST" : "LD", sz, a, d, rd, err, lat, stall_cyc);
        check_eq("rsp_rdata", rd, exp_rd);
        check_eq("rsp_err", 32'(err), 32'(exp_err));
        check_eq("latency", 32'(lat), 32'(ws_of(w) + 2));
        check_eq("stall_cycles", 32'(stall_cyc), 32'(ws_of(w) + 1));
    endtask

    task automatic check_idle(input int w, input string tag);
        check_eq({tag, "_stall"}, 32'(g_stall(w)), 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(g_rv(w)), 32'd0);
        check_eq({tag, "_rsp_rdata"}, g_rd(w), 32'd0);
        check_eq({tag, "_rsp_err"}, 32'(g_err(w)), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, a;
        int          pulses;
        reset_a = 1'b1; reset_b = 1'b1;
        drive(0, 0, 0, 2'd0, 32'd0, 32'd0);
        drive(1, 0, 0, 2'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_idle(0, "reset_a");
        check_idle(1, "reset_b");
        reset_a = 1'b0; reset_b = 1'b0;

        // Known contents for the reset and random regions.
        op(0, 1, SZ_WORD, 32'h10, 32'h11112222, rd);
        for (int i = 0; i < 16; i++) begin
            op(0, 1, SZ_WORD, 32'h40 + 32'(i*4), $urandom, rd);
            op(1, 1, SZ_WORD, 32'h40 + 32'(i*4), $urandom, rd);
        end

        // Reset while BUSY with one wait cycle left: the store must vanish.
        @(negedge clk);
        drive(0, 1, 1, SZ_WORD, 32'h10, 32'hDEADBEEF);
        repeat (3) begin @(posedge clk); #1; end
        check_eq("rst_mid_busy_pre", 32'(g_stall(0)), 32'd1);
        reset_a = 1'b1;
        drive(0, 0, 0, 2'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        reset_a = 1'b0;
        check_idle(0, "rst_mid_busy");
        pulses = 0;
        repeat (6) begin @(posedge clk); #1; if (g_rv(0)) pulses++; end
        check_eq("rst_no_rsp", 32'(pulses), 32'd0);
        op(0, 0, SZ_WORD, 32'h10, 32'd0, rd);
        check_eq("t1_old_value", rd, 32'h11112222);

        op(0, 1, SZ_WORD, 32'h20, 32'h12345678, rd);
        op(0, 0, SZ_WORD, 32'h20, 32'd0, rd);
        check_eq("t2_lw", rd, 32'h12345678);
        op(0, 1, SZ_BYTE, 32'h21, 32'h000000AB, rd);
        op(0, 0, SZ_WORD, 32'h20, 32'd0, rd);
        check_eq("t3_lw", rd, 32'h1234AB78);
        op(0, 0, SZ_BYTE, 32'h21, 32'd0, rd);
        check_eq("t3_lb", rd, 32'h000000AB);
        op(0, 1, SZ_HALF, 32'h22, 32'h0000BEEF, rd);
        op(0, 0, SZ_HALF, 32'h22, 32'd0, rd);
        check_eq("t4_lh", rd, 32'h0000BEEF);
        op(0, 0, SZ_WORD, 32'h20, 32'd0, rd);
        check_eq("t4_lw", rd, 32'hBEEFAB78);
        op(0, 0, SZ_WORD, 32'h22, 32'd0, rd);
        op(0, 1, SZ_HALF, 32'h23, 32'h00005555, rd);
        op(0, 0, SZ_WORD, 32'h20, 32'd0, rd);
        check_eq("t5_unchanged", rd, 32'hBEEFAB78);

        op(1, 1, SZ_WORD, (32'd1 << 12) + 32'h4, 32'hCAFEF00D, rd);
        op(1, 0, SZ_WORD, 32'h4, 32'd0, rd);
        check_eq("t6_wrap", rd, 32'hCAFEF00D);

        for (int i = 0; i < 60; i++) begin
            for (int w = 0; w < 2; w++) begin
                a = ($urandom & 32'hFFFF_F000) | (32'h40 + 32'($urandom_range(0, 63)));
                op(w, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, rd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
